fetch_queue: RTL and testbench

//  Instruction buffer directly downstream of the I-cache. Captures each dual-instruction fetch

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue_ram.sv | 31 +++
 rtl/fetch_queue.sv | 114 +++++++++++
 tb/tb_fetch_queue.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: the stored entry (PC + instruction) and the
// dual-slot response helpers.
package fetch_queue_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    addr_t pc;
    word_t inst;
  } fetch_entry_t;

  localparam int FETCH_WIDTH = 2;

  // Number of instructions carried by a response; slot 2'b01 -> 1, 2'b11 -> 2.
  function automatic logic [1:0] slot_count(input logic [1:0] slot);
    return {1'b0, slot[0]} + {1'b0, slot[1]};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode-facing handshake of the fetch queue. The master is the fetch and
// decode side; the slave is the queue itself.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic                           flush;
  logic                           can_fetch;
  logic                           req_fire;
  logic                           resp_valid;
  addr_t                          resp_pc;
  logic [1:0]                     resp_slot;
  logic [63:0]                    resp_data;
  logic [FETCH_WIDTH-1:0]         out_valid;
  addr_t [FETCH_WIDTH-1:0]        out_pc;
  word_t [FETCH_WIDTH-1:0]        out_inst;
  logic [1:0]                     pop_cnt;

  modport master (
    output flush, req_fire, resp_valid, resp_pc, resp_slot, resp_data, pop_cnt,
    input  can_fetch, out_valid, out_pc, out_inst
  );

  modport slave (
    input  flush, req_fire, resp_valid, resp_pc, resp_slot, resp_data, pop_cnt,
    output can_fetch, out_valid, out_pc, out_inst
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: two synchronous write ports (tail, tail+1)
// and two asynchronous read ports (head, head+1).
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  fetch_entry_t             wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  fetch_entry_t             wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output fetch_entry_t             rdata0_o,
  output fetch_entry_t             rdata1_o
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer behind the I-cache: reserves space per fetch, drops stale
// responses after a flush. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  fetch_queue_if.slave fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W+1:0] USED_MAX = (PTR_W+2)'(DEPTH - 2);

  logic [PTR_W:0]   head_q, head_d, tail_q, tail_d, count;
  logic [PTR_W+1:0] reserved_q, reserved_d, used;
  logic [PTR_W:0]   drop_q, drop_d, drop_sum;
  logic [1:0]       n_push, n_write, avail, pop_eff, wr_start;
  logic             acc, bypass, we0, we1;
  fetch_entry_t [1:0] resp_e;
  fetch_entry_t     wr0, rd0, rd1;

  assign count          = tail_q - head_q;
  assign used           = {1'b0, count} + reserved_q;
  assign fq.can_fetch   = resetn && (used <= USED_MAX);
  assign n_push         = slot_count(fq.resp_slot);
  assign acc            = fq.resp_valid && !fq.flush && (drop_q == '0) && (reserved_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = acc && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  // While bypassing, the response itself is what decode can pop this cycle.
  assign avail    = bypass ? n_push : ((count >= (PTR_W+1)'(2)) ? 2'd2 : count[1:0]);
  assign pop_eff  = (fq.pop_cnt > avail) ? avail : fq.pop_cnt;
  assign wr_start = bypass ? pop_eff : 2'd0;
  assign n_write  = n_push - wr_start;

  assign resp_e[0] = {fq.resp_pc, fq.resp_data[31:0]};
  assign resp_e[1] = {fq.resp_pc + 32'd4, fq.resp_data[63:32]};
  assign wr0       = wr_start[0] ? resp_e[1] : resp_e[0];
  assign we0       = acc && (n_write != 2'd0);
  assign we1       = acc && (n_write == 2'd2);

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk      (clk),
    .we0_i    (we0),
    .waddr0_i (tail_q[PTR_W-1:0]),
    .wdata0_i (wr0),
    .we1_i    (we1),
    .waddr1_i (tail_q[PTR_W-1:0] + PTR_W'(1)),
    .wdata1_i (resp_e[1]),
    .raddr0_i (head_q[PTR_W-1:0]),
    .raddr1_i (head_q[PTR_W-1:0] + PTR_W'(1)),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  always_comb begin
    fq.out_valid = {count >= (PTR_W+1)'(2), count != '0};
    fq.out_pc    = {rd1.pc, rd0.pc};
    fq.out_inst  = {rd1.inst, rd0.inst};
    if (bypass) begin
      fq.out_valid = {n_push == 2'd2, 1'b1};
      fq.out_pc    = {resp_e[1].pc, resp_e[0].pc};
      fq.out_inst  = {resp_e[1].inst, resp_e[0].inst};
    end
    if (!resetn) fq.out_valid = 2'b00;
  end

  // Requests still outstanding at a flush: older drops, live reservations, this cycle's fetch.
  assign drop_sum = drop_q + reserved_q[PTR_W+1:1] + (PTR_W+1)'(fq.req_fire);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    reserved_d = reserved_q;
    drop_d     = drop_q;
    if (fq.flush) begin
      head_d     = '0;
      tail_d     = '0;
      reserved_d = '0;
      drop_d     = (fq.resp_valid && (drop_sum != '0)) ? drop_sum - (PTR_W+1)'(1) : drop_sum;
    end else begin
      head_d     = head_q + (PTR_W+1)'(pop_eff);
      if (acc) tail_d = tail_q + (PTR_W+1)'(n_write);
      reserved_d = reserved_q + (fq.req_fire ? (PTR_W+2)'(2) : '0) - (acc ? (PTR_W+2)'(2) : '0);
      if (fq.resp_valid && (drop_q != '0)) drop_d = drop_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      reserved_q <= '0;
      drop_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      reserved_q <= reserved_d;
      drop_q     <= drop_d;
    end
  end

  a_pop_legal: assert property (@(posedge clk) disable iff (!resetn)
    fq.flush || (fq.pop_cnt <= avail));
  a_resp_expected: assert property (@(posedge clk) disable iff (!resetn)
    !(fq.resp_valid && !fq.flush && (drop_q == '0) && (reserved_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: vector table plus hand sequences, checked against a
// queue scoreboard of expected entries and reservation/drop bookkeeping.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam logic [1:0] BV11 = 2'b11;
  localparam logic [1:0] BV01 = 2'b01;
`else
  localparam logic [1:0] BV11 = 2'b00;
  localparam logic [1:0] BV01 = 2'b00;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if fq ();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .fq(fq));

  typedef struct {
    logic        req;
    logic        rv;
    logic [1:0]  slot;
    logic [31:0] pc;
    logic [63:0] data;
    logic [1:0]  pop;
    logic [1:0]  ev;
    logic        ecf;
    logic [31:0] epc0;
  } vec_t;

  int checks = 0;
  int failures = 0;
  fetch_entry_t mq[$];
  int m_res = 0;
  int m_drop = 0;
  logic        c_req, c_rv, c_fl;
  logic [1:0]  c_slot, c_pop;
  logic [31:0] c_pc;
  logic [63:0] c_data;
  vec_t tbl[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t row(input logic req, input logic rv, input logic [1:0] slot,
                               input logic [31:0] pc, input logic [63:0] data,
                               input logic [1:0] pop, input logic [1:0] ev,
                               input logic ecf, input logic [31:0] epc0);
    vec_t v;
    v.req = req; v.rv = rv; v.slot = slot; v.pc = pc; v.data = data;
    v.pop = pop; v.ev = ev; v.ecf = ecf; v.epc0 = epc0;
    return v;
  endfunction

  task automatic drive_idle();
    fq.req_fire = 0; fq.resp_valid = 0; fq.resp_slot = 2'b00; fq.resp_pc = '0;
    fq.resp_data = '0; fq.pop_cnt = 0; fq.flush = 0;
  endtask

  // Drive one cycle's inputs and compare outputs at the falling edge.
  task automatic apply(input logic req, input logic rv, input logic [1:0] slot,
                       input logic [31:0] pc, input logic [63:0] data,
                       input logic [1:0] pop, input logic fl);
    fetch_entry_t exp_e[$];
    fetch_entry_t e;
    bit byp;
    c_req = req; c_rv = rv; c_slot = slot; c_pc = pc; c_data = data; c_pop = pop; c_fl = fl;
    fq.req_fire = req; fq.resp_valid = rv; fq.resp_slot = slot; fq.resp_pc = pc;
    fq.resp_data = data; fq.pop_cnt = pop; fq.flush = fl;
    @(negedge clk);
    byp = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = rv && !fl && m_drop == 0 && m_res > 0 && mq.size() == 0;
`endif
    if (byp) begin
      e.pc = pc; e.inst = data[31:0]; exp_e.push_back(e);
      if (slot == 2'b11) begin e.pc = pc + 4; e.inst = data[63:32]; exp_e.push_back(e); end
    end else begin
      for (int i = 0; i < 2 && i < mq.size(); i++) exp_e.push_back(mq[i]);
    end
    chk("can_fetch", 64'(fq.can_fetch), 64'((DEPTH - mq.size() - m_res) >= 2));
    chk("out_valid", 64'(fq.out_valid), 64'({exp_e.size() >= 2, exp_e.size() >= 1}));
    for (int i = 0; i < exp_e.size(); i++) begin
      chk($sformatf("out_pc%0d", i), 64'(fq.out_pc[i]), 64'(exp_e[i].pc));
      chk($sformatf("out_inst%0d", i), 64'(fq.out_inst[i]), 64'(exp_e[i].inst));
    end
  endtask

  task automatic finish_cycle();
    fetch_entry_t e;
    int t;
    @(posedge clk);
    #1;
    if (c_fl) begin
      t = m_drop + m_res / 2 + int'(c_req);
      if (c_rv && t > 0) t--;
      m_drop = t; m_res = 0; mq.delete();
    end else begin
      if (c_rv && m_drop == 0 && m_res > 0) begin
        e.pc = c_pc; e.inst = c_data[31:0]; mq.push_back(e);
        if (c_slot == 2'b11) begin e.pc = c_pc + 4; e.inst = c_data[63:32]; mq.push_back(e); end
        m_res -= 2;
      end else if (c_rv && m_drop > 0) begin
        m_drop--;
      end
      for (int k = 0; k < int'(c_pop); k++) if (mq.size() > 0) void'(mq.pop_front());
      if (c_req) m_res += 2;
    end
  endtask

  task automatic cyc(input logic req, input logic rv, input logic [1:0] slot,
                     input logic [31:0] pc, input logic [63:0] data,
                     input logic [1:0] pop, input logic fl);
    apply(req, rv, slot, pc, data, pop, fl);
    finish_cycle();
  endtask

  initial begin
    drive_idle();
    tbl[0]  = row(1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0);
    tbl[1]  = row(0, 1, 2'b11, 32'hBFC00000, 64'h00000002_00000001, 0, BV11, 1, 32'hBFC00000);
    tbl[2]  = row(0, 0, 2'b00, 0, 0, 0, 2'b11, 1, 32'hBFC00000);
    tbl[3]  = row(0, 0, 2'b00, 0, 0, 2, 2'b11, 1, 32'hBFC00000);
    tbl[4]  = row(1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0);
    tbl[5]  = row(1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0);
    tbl[6]  = row(1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0);
    tbl[7]  = row(1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0);
    tbl[8]  = row(0, 1, 2'b11, 32'h100, 64'h00000011_00000010, 0, BV11, 0, 32'h100);
    tbl[9]  = row(0, 1, 2'b11, 32'h108, 64'h00000013_00000012, 0, 2'b11, 0, 32'h100);
    tbl[10] = row(0, 1, 2'b11, 32'h110, 64'h00000015_00000014, 0, 2'b11, 0, 32'h100);
    tbl[11] = row(0, 1, 2'b11, 32'h118, 64'h00000017_00000016, 0, 2'b11, 0, 32'h100);
    tbl[12] = row(0, 0, 2'b00, 0, 0, 0, 2'b11, 0, 32'h100);
    tbl[13] = row(0, 0, 2'b00, 0, 0, 2, 2'b11, 0, 32'h100);
    tbl[14] = row(0, 0, 2'b00, 0, 0, 0, 2'b11, 1, 32'h108);
    tbl[15] = row(0, 0, 2'b00, 0, 0, 2, 2'b11, 1, 32'h108);
    tbl[16] = row(0, 0, 2'b00, 0, 0, 2, 2'b11, 1, 32'h110);
    tbl[17] = row(0, 0, 2'b00, 0, 0, 2, 2'b11, 1, 32'h118);
    tbl[18] = row(1, 0, 2'b00, 0, 0, 0, 2'b00, 1, 0);
    tbl[19] = row(0, 1, 2'b01, 32'h1C, 64'h0000DEAD_00000077, 0, BV01, 1, 32'h1C);
    tbl[20] = row(0, 0, 2'b00, 0, 0, 0, 2'b01, 1, 32'h1C);
    tbl[21] = row(0, 0, 2'b00, 0, 0, 1, 2'b01, 1, 32'h1C);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_can_fetch", 64'(fq.can_fetch), 64'd0);
    chk("reset_out_valid", 64'(fq.out_valid), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i].req, tbl[i].rv, tbl[i].slot, tbl[i].pc, tbl[i].data, tbl[i].pop, 1'b0);
      chk($sformatf("vec%0d_valid", i), 64'(fq.out_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_can_fetch", i), 64'(fq.can_fetch), 64'(tbl[i].ecf));
      if (tbl[i].ev[0]) chk($sformatf("vec%0d_pc0", i), 64'(fq.out_pc[0]), 64'(tbl[i].epc0));
      finish_cycle();
    end

    // Flush between request and response: the response is dropped.
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 0, 1);
    cyc(0, 1, 2'b11, 32'h300, 64'h0000BAD1_0000BAD0, 0, 0);
    apply(1, 0, 2'b00, 0, 0, 0, 0);
    chk("flush_drop_valid", 64'(fq.out_valid), 64'd0);
    finish_cycle();
    cyc(0, 1, 2'b11, 32'h200, 64'h00000201_00000200, 0, 0);
    apply(0, 0, 2'b00, 0, 0, 2, 0);
    chk("after_flush_valid", 64'(fq.out_valid), 64'h3);
    chk("after_flush_pc0", 64'(fq.out_pc[0]), 64'h200);
    finish_cycle();

    // Flush with a same-cycle fetch: two responses to drop.
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0, 0, 0, 1);
    cyc(0, 1, 2'b11, 32'h400, 64'h0000BAD3_0000BAD2, 0, 0);
    cyc(0, 1, 2'b11, 32'h408, 64'h0000BAD5_0000BAD4, 0, 0);
    apply(1, 0, 2'b00, 0, 0, 0, 0);
    chk("flush_req_valid", 64'(fq.out_valid), 64'd0);
    finish_cycle();
    cyc(0, 1, 2'b11, 32'h600, 64'h00000601_00000600, 0, 0);
    apply(0, 0, 2'b00, 0, 0, 2, 0);
    chk("flush_req_pc0", 64'(fq.out_pc[0]), 64'h600);
    finish_cycle();

    // Flush with same-cycle fetch and same-cycle (discarded) response.
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 1, 2'b11, 32'h500, 64'h0000BAD7_0000BAD6, 0, 1);
    cyc(0, 1, 2'b11, 32'h508, 64'h0000BAD9_0000BAD8, 0, 0);
    cyc(1, 1, 2'b11, 32'h510, 64'h0000BADB_0000BADA, 0, 0);
    cyc(0, 1, 2'b01, 32'h700, 64'h0000BADC_00000700, 0, 0);
    apply(0, 0, 2'b00, 0, 0, 1, 0);
    chk("flush_resp_valid", 64'(fq.out_valid), 64'h1);
    chk("flush_resp_pc0", 64'(fq.out_pc[0]), 64'h700);
    finish_cycle();

    // Pointer wrap: 12 back-to-back dual fetches drained two per cycle.
    for (int i = 0; i < 14; i++) begin
      int p;
      p = (mq.size() >= 2) ? 2 : mq.size();
      cyc(i < 12, i >= 1 && i <= 12, 2'b11, 32'h1000 + 32'(8 * (i - 1)),
          {32'hC000_0000 + 32'(2 * i + 1), 32'hC000_0000 + 32'(2 * i)}, 2'(p), 0);
    end
    apply(0, 0, 2'b00, 0, 0, 0, 0);
    chk("wrap_drained", 64'(fq.out_valid), 64'd0);
    finish_cycle();

`ifdef FETCH_QUEUE_BYPASS_EN
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    apply(0, 1, 2'b11, 32'h80, 64'h00000084_00000080, 1, 0);
    chk("bypass_pc0", 64'(fq.out_pc[0]), 64'h80);
    finish_cycle();
    apply(0, 0, 2'b00, 0, 0, 1, 0);
    chk("bypass_next_valid", 64'(fq.out_valid), 64'h1);
    chk("bypass_next_pc0", 64'(fq.out_pc[0]), 64'h84);
    finish_cycle();
`endif

    // Reset in the middle of operation.
    cyc(1, 0, 2'b00, 0, 0, 0, 0);
    cyc(1, 1, 2'b11, 32'h900, 64'h00000901_00000900, 0, 0);
    drive_idle();
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_can_fetch", 64'(fq.can_fetch), 64'd0);
    chk("midreset_valid", 64'(fq.out_valid), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mq.delete(); m_res = 0; m_drop = 0;
    apply(0, 0, 2'b00, 0, 0, 0, 0);
    chk("postreset_valid", 64'(fq.out_valid), 64'd0);
    chk("postreset_can_fetch", 64'(fq.can_fetch), 64'd1);
    finish_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
